// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_pkg                                                   |
// | Description : Shared field widths and FSM state encoding for the direct-   |
// |               mapped write-back data cache.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dcache_pkg;

  // Address split of the 8-bit CPU byte address: tag [7:5], index [4:2], offset [1:0]
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;

  // Miss-handling state machine encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE      = 2'd0;
  localparam state_t WRITEBACK = 2'd1;
  localparam state_t ALLOCATE  = 2'd2;
  localparam state_t UPDATE    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_array                                                 |
// | Description : Tag, valid, dirty and data storage for the data cache.       |
// |               Combinational read of the indexed line, one byte-write port  |
// |               (sets dirty) and one whole-block fill port (sets tag and     |
// |               valid, clears dirty).                                        |
// | Ports       : CLK, RESET        - clock, sync active-high reset            |
// |               i_index           - line selected for read and both writes   |
// |               i_byte_we/offset/byte - CPU byte store into the line         |
// |               i_fill_we/tag/block   - block refill from main memory        |
// |               o_valid/dirty/tag/block - contents of the indexed line       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  i_index,
  input  logic                i_byte_we,
  input  logic [OFFSET_W-1:0] i_offset,
  input  logic [7:0]          i_byte,
  input  logic                i_fill_we,
  input  logic [TAG_W-1:0]    i_fill_tag,
  input  logic [BLOCK_W-1:0]  i_fill_block,
  output logic                o_valid,
  output logic                o_dirty,
  output logic [TAG_W-1:0]    o_tag,
  output logic [BLOCK_W-1:0]  o_block
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [BLOCK_W-1:0]   r_data [NUM_LINES];

  // Only the status bits need a reset; tag and data are ignored while invalid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_fill_we) begin
      r_tag[i_index]  <= i_fill_tag;
      r_data[i_index] <= i_fill_block;
    end else if (i_byte_we) begin
      r_data[i_index][{i_offset, 3'b000} +: 8] <= i_byte;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_block = r_data[i_index];

endmodule
`default_nettype wire

// File: rtl/dcache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache                                                       |
// | Description : Direct-mapped, write-back, write-allocate byte data cache.   |
// |               Hits complete with no stall; misses run a write-back /       |
// |               allocate / update sequence against a block-wide memory port. |
// | Ports       : CLK, RESET               - clock, sync active-high reset     |
// |               READ, WRITE, ADDRESS, WRITEDATA - CPU byte request           |
// |               READDATA, BUSYWAIT        - CPU load byte and stall          |
// |               MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA - to memory  |
// |               MEM_READDATA, MEM_BUSYWAIT                    - from memory  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dcache
  import dcache_pkg::*;
#(
  parameter int MEM_ADDR_W = 6,
  parameter int NUM_LINES  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [7:0]            ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  state_t r_state;
  state_t w_state_nxt;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic                w_req;
  logic                w_hit;
  logic                w_byte_we;
  logic                w_fill_we;
  logic                w_line_valid;
  logic                w_line_dirty;
  logic [TAG_W-1:0]    w_line_tag;
  logic [BLOCK_W-1:0]  w_line_block;

  assign w_tag    = ADDRESS[7:5];
  assign w_index  = ADDRESS[4:2];
  assign w_offset = ADDRESS[1:0];
  assign w_req    = READ | WRITE;
  assign w_hit    = w_line_valid && (w_line_tag == w_tag);

  // A simultaneous READ and WRITE is a write; the read port just shows the old byte.
  assign w_byte_we = !RESET && (r_state == IDLE) && WRITE && w_hit;
  assign w_fill_we = !RESET && (r_state == ALLOCATE) && !MEM_BUSYWAIT;

  dcache_array #(
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_index      (w_index),
    .i_byte_we    (w_byte_we),
    .i_offset     (w_offset),
    .i_byte       (WRITEDATA),
    .i_fill_we    (w_fill_we),
    .i_fill_tag   (w_tag),
    .i_fill_block (MEM_READDATA),
    .o_valid      (w_line_valid),
    .o_dirty      (w_line_dirty),
    .o_tag        (w_line_tag),
    .o_block      (w_line_block)
  );

  // Once a miss leaves IDLE the sequence runs to completion even if the CPU
  // withdraws its request; only RESET abandons it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_req && !w_hit)
                   w_state_nxt = (w_line_valid && w_line_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (!MEM_BUSYWAIT) w_state_nxt = ALLOCATE;
      ALLOCATE:  if (!MEM_BUSYWAIT) w_state_nxt = UPDATE;
      UPDATE:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  assign BUSYWAIT = !RESET && w_req && ((r_state != IDLE) || !w_hit);
  assign READDATA = w_line_block[{w_offset, 3'b000} +: 8];

  assign MEM_WRITE     = (r_state == WRITEBACK);
  assign MEM_READ      = (r_state == ALLOCATE);
  // The victim goes back to the block it came from; refills use the CPU address.
  assign MEM_ADDRESS   = (r_state == WRITEBACK) ? {w_line_tag, w_index} : ADDRESS[7:2];
  assign MEM_WRITEDATA = w_line_block;

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dcache                                                    |
// | Description : Directed self-checking bench for dcache with a fixed-latency |
// |               (L=4) block memory model.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dcache;

  localparam int L = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  dcache #(.MEM_ADDR_W(6), .NUM_LINES(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // ---------------- main memory model ----------------
  function automatic logic [31:0] init_word(input logic [5:0] a);
    case (a)
      6'd0:    return 32'h44332211;
      6'd1:    return 32'h0F0E0D0C;
      6'd8:    return 32'hDDCCBBAA;
      6'd17:   return 32'h87654321;
      6'd32:   return 32'h13579BDF;
      6'd40:   return 32'h24681357;
      default: return {4{2'b10, a}};
    endcase
  endfunction

  logic [31:0] wmem [64];
  bit   [63:0] wvalid;
  int          cnt = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [5:0]  last_rd_addr = '0;
  logic [5:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt != L);
  assign MEM_READDATA = wvalid[MEM_ADDRESS] ? wmem[MEM_ADDRESS] : init_word(MEM_ADDRESS);

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) begin
      if (cnt == L) begin
        cnt <= 0;
        if (MEM_WRITE) begin
          wmem[MEM_ADDRESS]   <= MEM_WRITEDATA;
          wvalid[MEM_ADDRESS] <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
    if (MEM_READ) begin
      rd_cycles    <= rd_cycles + 1;
      last_rd_addr <= MEM_ADDRESS;
    end
    if (MEM_WRITE) begin
      wr_cycles    <= wr_cycles + 1;
      last_wr_addr <= MEM_ADDRESS;
      last_wr_data <= MEM_WRITEDATA;
    end
  end

  // ---------------- CPU access driver ----------------
  // Presents a request, counts cycles with BUSYWAIT high, samples READDATA in
  // the completing cycle, then lets the completing edge pass.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, output int stalls, output logic [7:0] rdata);
    stalls = 0;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    #1;
    while (BUSYWAIT === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge CLK);
      #1;
    end
    rdata = READDATA;
    @(posedge CLK);
    #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    RESET = 1'b1;
    READ  = 1'b1;
    ADDRESS = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if (BUSYWAIT !== 1'b0) begin miscompares++; $display("FAIL reset_busywait got=%b exp=0", BUSYWAIT); end
    vectors++;
    if (MEM_READ !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read got=%b exp=0", MEM_READ); end
    vectors++;
    if (MEM_WRITE !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write got=%b exp=0", MEM_WRITE); end
    @(negedge CLK);
    READ = 1'b0;
    RESET = 1'b0;
  endtask

  task automatic test_clean_miss;
    int s; logic [7:0] r; int rc0; int wc0;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    rc0 = rd_cycles; wc0 = wr_cycles;
    access(1'b1, 1'b0, 8'h00, 8'h00, s, r);
    vectors++;
    if (s != L + 3) begin miscompares++; $display("FAIL clean_miss_stall got=%0d exp=%0d", s, L + 3); end
    vectors++;
    if (r !== 8'h11) begin miscompares++; $display("FAIL clean_miss_data got=%h exp=11", r); end
    vectors++;
    if (rd_cycles - rc0 != L + 1) begin miscompares++; $display("FAIL clean_miss_memread_cycles got=%0d exp=%0d", rd_cycles - rc0, L + 1); end
    vectors++;
    if (last_rd_addr !== 6'd0) begin miscompares++; $display("FAIL clean_miss_memaddr got=%h exp=00", last_rd_addr); end
    vectors++;
    if (wr_cycles != wc0) begin miscompares++; $display("FAIL clean_miss_no_memwrite got=%0d exp=0", wr_cycles - wc0); end
    for (int i = 1; i < 4; i++) begin
      access(1'b1, 1'b0, 8'(i), 8'h00, s, r);
      vectors++;
      if (s != 0) begin miscompares++; $display("FAIL hit_stall[%0d] got=%0d exp=0", i, s); end
      vectors++;
      if (r !== exp_b[i]) begin miscompares++; $display("FAIL hit_data[%0d] got=%h exp=%h", i, r, exp_b[i]); end
    end
  endtask

  task automatic test_write_hit;
    int s; logic [7:0] r;
    access(1'b0, 1'b1, 8'h01, 8'hAB, s, r);
    vectors++;
    if (s != 0) begin miscompares++; $display("FAIL write_hit_stall got=%0d exp=0", s); end
    access(1'b1, 1'b0, 8'h01, 8'h00, s, r);
    vectors++;
    if (s != 0 || r !== 8'hAB) begin miscompares++; $display("FAIL write_hit_readback got=%h/%0d exp=ab/0", r, s); end
  endtask

  task automatic test_dirty_miss;
    int s; logic [7:0] r; int wc0;
    wc0 = wr_cycles;
    access(1'b1, 1'b0, 8'h21, 8'h00, s, r);
    vectors++;
    if (s != 2 * L + 4) begin miscompares++; $display("FAIL dirty_miss_stall got=%0d exp=%0d", s, 2 * L + 4); end
    vectors++;
    if (wr_cycles - wc0 != L + 1) begin miscompares++; $display("FAIL dirty_miss_memwrite_cycles got=%0d exp=%0d", wr_cycles - wc0, L + 1); end
    vectors++;
    if (last_wr_addr !== 6'd0) begin miscompares++; $display("FAIL dirty_miss_wb_addr got=%h exp=00", last_wr_addr); end
    vectors++;
    if (last_wr_data !== 32'h4433AB11) begin miscompares++; $display("FAIL dirty_miss_wb_data got=%h exp=4433ab11", last_wr_data); end
    vectors++;
    if (last_rd_addr !== 6'd8) begin miscompares++; $display("FAIL dirty_miss_fill_addr got=%h exp=08", last_rd_addr); end
    vectors++;
    if (r !== 8'hBB) begin miscompares++; $display("FAIL dirty_miss_data got=%h exp=bb", r); end
  endtask

  task automatic test_write_miss_clean;
    int s; logic [7:0] r; int wc0;
    wc0 = wr_cycles;
    access(1'b0, 1'b1, 8'h45, 8'h5A, s, r);
    vectors++;
    if (s != L + 3) begin miscompares++; $display("FAIL write_miss_stall got=%0d exp=%0d", s, L + 3); end
    vectors++;
    if (wr_cycles != wc0) begin miscompares++; $display("FAIL write_miss_no_memwrite got=%0d exp=0", wr_cycles - wc0); end
    access(1'b1, 1'b0, 8'h45, 8'h00, s, r);
    vectors++;
    if (s != 0 || r !== 8'h5A) begin miscompares++; $display("FAIL write_miss_readback got=%h/%0d exp=5a/0", r, s); end
    // Evicting the line proves it was left dirty with the merged byte.
    access(1'b1, 1'b0, 8'h05, 8'h00, s, r);
    vectors++;
    if (s != 2 * L + 4) begin miscompares++; $display("FAIL write_miss_evict_stall got=%0d exp=%0d", s, 2 * L + 4); end
    vectors++;
    if (last_wr_addr !== 6'h11 || last_wr_data !== 32'h87655A21) begin
      miscompares++; $display("FAIL write_miss_evict_wb got=%h:%h exp=11:87655a21", last_wr_addr, last_wr_data);
    end
    vectors++;
    if (r !== 8'h0D) begin miscompares++; $display("FAIL write_miss_evict_data got=%h exp=0d", r); end
  endtask

  task automatic test_reset_mid_miss;
    int s; logic [7:0] r;
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h81;
    repeat (2) @(negedge CLK);
    vectors++;
    if (MEM_READ !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_allocate got=%b exp=1", MEM_READ); end
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK);
    #1;
    vectors++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_dropped got mem_read=%b busywait=%b exp=0/0", MEM_READ, BUSYWAIT);
    end
    @(negedge CLK);
    RESET = 1'b0;
    access(1'b1, 1'b0, 8'h81, 8'h00, s, r);
    vectors++;
    if (s != L + 3) begin miscompares++; $display("FAIL rst_mid_remiss_stall got=%0d exp=%0d", s, L + 3); end
    vectors++;
    if (r !== 8'h9B) begin miscompares++; $display("FAIL rst_mid_remiss_data got=%h exp=9b", r); end
  endtask

  task automatic test_read_write_both;
    int s; logic [7:0] r;
    access(1'b1, 1'b1, 8'h82, 8'hC3, s, r);
    vectors++;
    if (s != 0) begin miscompares++; $display("FAIL rw_both_stall got=%0d exp=0", s); end
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h82;
    #1;
    vectors++;
    if (READDATA !== 8'hC3 || BUSYWAIT !== 1'b0) begin
      miscompares++; $display("FAIL rw_both_readback got=%h/%b exp=c3/0", READDATA, BUSYWAIT);
    end
    READ = 1'b0;
    access(1'b1, 1'b0, 8'hA2, 8'h00, s, r);
    vectors++;
    if (s != 2 * L + 4 || last_wr_addr !== 6'h20 || last_wr_data !== 32'h13C39BDF) begin
      miscompares++; $display("FAIL rw_both_evict got=%0d %h:%h exp=%0d 20:13c39bdf", s, last_wr_addr, last_wr_data, 2 * L + 4);
    end
    vectors++;
    if (r !== 8'h68) begin miscompares++; $display("FAIL rw_both_evict_data got=%h exp=68", r); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_miss();
    test_write_miss_clean();
    test_reset_mid_miss();
    test_read_write_both();
    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
